hazard_unit_mdu: RTL and testbench
==================================

Name: hazard_unit_mdu

Overview:
- Parametrised successor to the pipeline hazard unit for the 5-stage MIPS core.
- Keeps the existing behaviour: E-stage ALU forwarding, D-stage branch-compare forwarding, load-use stall and branch stall.
- Adds a multi-cycle multiply/divide (MDU) busy tracker that stalls HI/LO consumers and back-to-back MDU ops.
- Adds saturating per-cause stall performance counters.
- Sits beside the datapath; drives stall/flush/forward selects to the pipeline registers and muxes.

Parameters:
- REG_W, 5, register-address width (2**REG_W architectural registers; register 0 hard-wired zero).
- MDU_LATENCY, 4, cycles the MDU stays busy after an MDU op occupies E; legal 1..31.
- CNT_W, 16, width of each stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- rsD, rtD, rsE, rtE  in  REG_W each  source register fields in D and E.
- writeregE, writeregM, writeregW  in  REG_W each  destination registers.
- regwriteE, regwriteM, regwriteW  in  1 each  register-write enables.
- memtoregE, memtoregM  in  2 each  nonzero = load.
- branchD, branchNOTD  in  1 each  beq/bne in D.
- mdu_startD, mdu_startE  in  1 each  mult/div instruction in D / E.
- hilo_readD  in  1  mfhi/mflo in D.
- stat_clr  in  1  synchronous clear of performance counters.
- forwardaD, forwardbD  out  1 each  branch operand from M.
- forwardaE, forwardbE  out  2 each  ALU operand select: 00 regfile, 01 W, 10 M.
- stallF, stallD, flushE  out  1 each.
- mdu_busy  out  1  MDU counter nonzero.
- lw_stall_cnt, br_stall_cnt, mdu_stall_cnt  out  CNT_W each.

Behaviour:
- Reset (reset_n low, asynchronous):
  - MDU counter = 0; all performance counters = 0.
  - Consequently mdu_busy = 0; with idle inputs all stall/flush/forward outputs = 0.
- Forwarding (combinational):
  - forwardaE = 10 if rsE != 0 & rsE == writeregM & regwriteM.
  - Else forwardaE = 01 if rsE != 0 & rsE == writeregW & regwriteW.
  - Else forwardaE = 00.
  - forwardbE is identical using rtE.
  - M beats W when both match.
  - forwardaD = rsD != 0 & rsD == writeregM & regwriteM; forwardbD likewise with rtD.
- lwstall:
  - memtoregE != 0 & rtE != 0 & (rtE == rsD | rtE == rtD).
- brstall:
  - (branchD | branchNOTD) & [ (regwriteE & writeregE != 0 & (writeregE == rsD | writeregE == rtD)) | (memtoregM != 0 & writeregM != 0 & (writeregM == rsD | writeregM == rtD)) ].
- MDU counter (cnt, width ceil(log2(MDU_LATENCY+1))):
  - If mdu_startE, load cnt = MDU_LATENCY on the next edge.
  - Else if cnt != 0, decrement.
  - Else hold.
  - mdu_startE while cnt != 0 cannot occur (it is stalled in D); if it does, reload takes priority.
  - mdu_busy = cnt != 0.
- mdustall:
  - (hilo_readD | mdu_startD) & (mdu_startE | cnt != 0).
  - With MDU_LATENCY = L, a consumer directly behind an MDU op stalls L+1 cycles (1 while the op is in E, L while busy).
- Stall outputs:
  - stallD = lwstall | brstall | mdustall; stallF = stallD; flushE = stallD.
  - These are combinational from inputs and cnt; no added latency.
- Performance counters (one per cause, sampled each rising edge):
  - If stat_clr, clear to 0; stat_clr has priority over increment.
  - Else if the cause is active and the counter is not all-ones, increment.
  - Counters saturate at 2**CNT_W-1 and never wrap.
  - Simultaneous causes each increment their own counter.
- Reset mid-stall: counters and cnt clear immediately; stalls derived from cnt drop asynchronously.
- No stall output depends on the performance counters.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t (2-bit enum FWD_RF=00, FWD_W=01, FWD_M=10).
  - Load-detect helper constant MEMTOREG_ALU=2'b00.
- Sub-module sat_counter:
  - Parameter CNT_W; inputs clk, reset_n, clr, inc; output count.
  - Instantiated three times.
- MDU counter stays inline.

Test Plan:
- Reset then idle → all outputs 0; then writeregM=5, regwriteM=1, rsE=5, rtE=5 with writeregW=5, regwriteW=1 → forwardaE=forwardbE=10; rsE=0 → forwardaE=00.
- Load-use: memtoregE=01, rtE=7, rsD=7 → stallD=stallF=flushE=1 for 1 cycle, lw_stall_cnt 0→1; rtE=0 → no stall.
- Branch: branchD=1, regwriteE=1, writeregE=3, rtD=3 → stall; next cycle memtoregM=01, writeregM=3 → stall; then regwriteM=1, writeregM=3 → forwardbD=1, no stall; br_stall_cnt=2.
- MDU, MDU_LATENCY=4: mdu_startE=1 with hilo_readD=1 held → stallD high exactly 5 cycles, mdu_busy high 4 cycles, mdu_stall_cnt=5; mdu_startD behind it behaves identically.
- Saturation/clear with CNT_W=3: hold lwstall 10 cycles → lw_stall_cnt=7; stat_clr together with lwstall → 0 next cycle, then increments.
- Async reset with cnt=3: drop reset_n between edges → mdu_busy and stallD fall immediately; all counters read 0 after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the MDU-aware hazard unit
package hazard_pkg;
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;
  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
endpackage

// File: rtl/hazard_unit_mdu_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear
//   clk, reset_n : clock, async active-low reset
//   clr          : synchronous clear, beats inc
//   inc          : count this cycle
//   count        : current value, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && count_q != '1) ? count_q + CNT_W'(1) : count_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/hazard_unit_mdu.sv
// hazard_unit_mdu: 5-stage MIPS hazard unit with forwarding, load/branch/MDU stalls and stall counters
//   rs/rt D,E, writereg E/M/W, regwrite E/M/W, memtoreg E/M : pipeline register fields
//   branchD/branchNOTD, mdu_startD/E, hilo_readD            : instruction class flags
//   stat_clr                                                : clears performance counters
//   forward*D/E, stallF, stallD, flushE                     : pipeline control
//   mdu_busy, *_stall_cnt                                   : MDU status and stall statistics
module hazard_unit_mdu
  import hazard_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic [REG_W-1:0] rsE,
  input  logic [REG_W-1:0] rtE,
  input  logic [REG_W-1:0] writeregE,
  input  logic [REG_W-1:0] writeregM,
  input  logic [REG_W-1:0] writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic [1:0]       memtoregE,
  input  logic [1:0]       memtoregM,
  input  logic             branchD,
  input  logic             branchNOTD,
  input  logic             mdu_startD,
  input  logic             mdu_startE,
  input  logic             hilo_readD,
  input  logic             stat_clr,
  output logic             forwardaD,
  output logic             forwardbD,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] lw_stall_cnt,
  output logic [CNT_W-1:0] br_stall_cnt,
  output logic [CNT_W-1:0] mdu_stall_cnt
);
  localparam int MW = $clog2(MDU_LATENCY + 1);
  logic [MW-1:0] cnt_q, cnt_d;
  logic lwstall, brstall, mdustall;
  fwd_sel_t fwd_a, fwd_b;
  always_comb begin
    fwd_a = (rsE != '0 && rsE == writeregM && regwriteM) ? FWD_M :
            (rsE != '0 && rsE == writeregW && regwriteW) ? FWD_W : FWD_RF;
    fwd_b = (rtE != '0 && rtE == writeregM && regwriteM) ? FWD_M :
            (rtE != '0 && rtE == writeregW && regwriteW) ? FWD_W : FWD_RF;
  end
  assign forwardaE = fwd_a;
  assign forwardbE = fwd_b;
  assign forwardaD = rsD != '0 && rsD == writeregM && regwriteM;
  assign forwardbD = rtD != '0 && rtD == writeregM && regwriteM;
  assign lwstall  = memtoregE != MEMTOREG_ALU && rtE != '0 && (rtE == rsD || rtE == rtD);
  assign brstall  = (branchD || branchNOTD) &&
                    ((regwriteE && writeregE != '0 && (writeregE == rsD || writeregE == rtD)) ||
                     (memtoregM != MEMTOREG_ALU && writeregM != '0 && (writeregM == rsD || writeregM == rtD)));
  // The op sitting in E counts as busy too, so a consumer directly behind it stalls L+1 cycles.
  assign mdustall = (hilo_readD || mdu_startD) && (mdu_startE || cnt_q != '0);
  assign stallD   = lwstall || brstall || mdustall;
  assign stallF   = stallD;
  assign flushE   = stallD;
  assign mdu_busy = cnt_q != '0;
  always_comb cnt_d = mdu_startE ? MW'(MDU_LATENCY) : (cnt_q != '0) ? cnt_q - MW'(1) : cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  sat_counter #(.CNT_W(CNT_W)) u_lw  (.clk(clk), .reset_n(reset_n), .clr(stat_clr), .inc(lwstall),  .count(lw_stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_br  (.clk(clk), .reset_n(reset_n), .clr(stat_clr), .inc(brstall),  .count(br_stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_mdu (.clk(clk), .reset_n(reset_n), .clr(stat_clr), .inc(mdustall), .count(mdu_stall_cnt));
endmodule

// File: tb/tb_hazard_unit_mdu.sv
// tb_hazard_unit_mdu: directed test with a reference model checked every cycle
module tb_hazard_unit_mdu;
  localparam int L = 4;
  localparam int CW = 3;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 0, reset_n = 0;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, branchD, branchNOTD, mdu_startD, mdu_startE, hilo_readD, stat_clr;
  logic [1:0] memtoregE, memtoregM, forwardaE, forwardbE;
  logic forwardaD, forwardbD, stallF, stallD, flushE, mdu_busy;
  logic [CW-1:0] lw_stall_cnt, br_stall_cnt, mdu_stall_cnt;
  int checks = 0, errors = 0;
  int m_left = 0, m_lw = 0, m_br = 0, m_mdu = 0;
  always #5 clk = ~clk;
  hazard_unit_mdu #(.REG_W(5), .MDU_LATENCY(L), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD), .branchNOTD(branchNOTD),
    .mdu_startD(mdu_startD), .mdu_startE(mdu_startE), .hilo_readD(hilo_readD), .stat_clr(stat_clr),
    .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .flushE(flushE), .mdu_busy(mdu_busy),
    .lw_stall_cnt(lw_stall_cnt), .br_stall_cnt(br_stall_cnt), .mdu_stall_cnt(mdu_stall_cnt));
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int e_fwd(input int r);
    if (r != 0 && regwriteM && r == writeregM) return 2;
    if (r != 0 && regwriteW && r == writeregW) return 1;
    return 0;
  endfunction
  function automatic bit e_lw();
    return memtoregE != 0 && rtE != 0 && (rtE == rsD || rtE == rtD);
  endfunction
  function automatic bit e_br();
    bit hit_e, hit_m;
    hit_e = regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
    hit_m = memtoregM != 0 && writeregM != 0 && (writeregM == rsD || writeregM == rtD);
    return (branchD || branchNOTD) && (hit_e || hit_m);
  endfunction
  function automatic bit e_mdu();
    return (hilo_readD || mdu_startD) && (mdu_startE || m_left > 0);
  endfunction
  function automatic int bump(input int c, input bit cause);
    if (stat_clr) return 0;
    return (cause && c < MAXC) ? c + 1 : c;
  endfunction
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0; m_lw = 0; m_br = 0; m_mdu = 0;
    end else begin
      m_lw  = bump(m_lw, e_lw());
      m_br  = bump(m_br, e_br());
      m_mdu = bump(m_mdu, e_mdu());
      m_left = mdu_startE ? L : (m_left > 0 ? m_left - 1 : 0);
    end
  end
  always @(negedge clk) if (reset_n) begin
    bit s;
    s = e_lw() || e_br() || e_mdu();
    chk("fwdaE", forwardaE, e_fwd(rsE));
    chk("fwdbE", forwardbE, e_fwd(rtE));
    chk("fwdaD", forwardaD, rsD != 0 && regwriteM && rsD == writeregM);
    chk("fwdbD", forwardbD, rtD != 0 && regwriteM && rtD == writeregM);
    chk("stallD", stallD, s);
    chk("stallF", stallF, s);
    chk("flushE", flushE, s);
    chk("mdu_busy", mdu_busy, m_left > 0);
    chk("lw_cnt", lw_stall_cnt, m_lw);
    chk("br_cnt", br_stall_cnt, m_br);
    chk("mdu_cnt", mdu_stall_cnt, m_mdu);
  end
  task automatic tick; @(posedge clk); #1; endtask
  task automatic idle;
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, branchD, branchNOTD, mdu_startD, mdu_startE, hilo_readD, stat_clr} = '0;
    memtoregE = 0; memtoregM = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int sc, bc;
    idle();
    #12 reset_n = 1;
    tick();
    chk("idle_stall", stallD, 0); chk("idle_fwdaE", forwardaE, 0); chk("idle_busy", mdu_busy, 0);
    chk("idle_lw", lw_stall_cnt, 0); chk("idle_br", br_stall_cnt, 0); chk("idle_mdu", mdu_stall_cnt, 0);
    writeregM = 5; regwriteM = 1; rsE = 5; rtE = 5; writeregW = 5; regwriteW = 1; #1;
    chk("fwd_m_a", forwardaE, 2); chk("fwd_m_b", forwardbE, 2);
    rsE = 0; #1;
    chk("fwd_r0_a", forwardaE, 0); chk("fwd_r0_b", forwardbE, 2);
    regwriteM = 0; #1;
    chk("fwd_w_b", forwardbE, 1);
    tick(); idle();
    memtoregE = 1; rtE = 7; rsD = 7; #1;
    chk("lw_stallD", stallD, 1); chk("lw_stallF", stallF, 1); chk("lw_flushE", flushE, 1);
    tick(); rtE = 0; #1;
    chk("lw_cnt1", lw_stall_cnt, 1); chk("lw_rt0", stallD, 0);
    tick(); chk("lw_cnt_hold", lw_stall_cnt, 1);
    idle();
    branchD = 1; regwriteE = 1; writeregE = 3; rtD = 3; #1;
    chk("br_e", stallD, 1);
    tick(); regwriteE = 0; memtoregM = 1; writeregM = 3; #1;
    chk("br_m_load", stallD, 1);
    tick(); memtoregM = 0; regwriteM = 1; #1;
    chk("br_fwdbD", forwardbD, 1); chk("br_nostall", stallD, 0);
    tick(); chk("br_cnt2", br_stall_cnt, 2);
    idle();
    for (int v = 0; v < 2; v++) begin
      stat_clr = 1; tick(); stat_clr = 0; #1;
      chk("mdu_clr", mdu_stall_cnt, 0);
      mdu_startE = 1; hilo_readD = (v == 0); mdu_startD = (v == 1); #1;
      sc = 0; bc = 0;
      for (int i = 0; i < 8; i++) begin
        sc += int'(stallD); bc += int'(mdu_busy);
        tick();
        mdu_startE = 0; #1;
      end
      chk("mdu_stall_cycles", sc, L + 1); chk("mdu_busy_cycles", bc, L);
      chk("mdu_cnt5", mdu_stall_cnt, 5);
      idle();
    end
    memtoregE = 1; rtE = 7; rsD = 7;
    for (int i = 0; i < 10; i++) tick();
    chk("lw_sat", lw_stall_cnt, 7);
    stat_clr = 1; tick(); stat_clr = 0; #1;
    chk("lw_clr", lw_stall_cnt, 0);
    tick(); chk("lw_after_clr", lw_stall_cnt, 1);
    idle();
    mdu_startE = 1; tick(); mdu_startE = 0; tick();
    hilo_readD = 1; branchD = 1; regwriteE = 1; writeregE = 4; rsD = 4; #1;
    chk("ar_busy_pre", mdu_busy, 1); chk("ar_stall_pre", stallD, 1);
    branchD = 0; regwriteE = 0; #1;
    reset_n = 0; #1;
    chk("ar_busy", mdu_busy, 0); chk("ar_stall", stallD, 0);
    chk("ar_lw", lw_stall_cnt, 0); chk("ar_br", br_stall_cnt, 0); chk("ar_mdu", mdu_stall_cnt, 0);
    #2 reset_n = 1;
    hilo_readD = 0;
    tick();
    chk("post_lw", lw_stall_cnt, 0); chk("post_br", br_stall_cnt, 0); chk("post_mdu", mdu_stall_cnt, 0);
    chk("post_busy", mdu_busy, 0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
